// File: rtl/target_mem_pkg.sv
// Shared types and constants for the target-side byte memory core.
package target_mem_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WR_WAIT_DATA = 2'd1,
        RD_WAIT      = 2'd2,
        RD_SPLIT     = 2'd3
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int BUS_ADDR_WIDTH = 16;
    localparam int BUS_DATA_WIDTH = 8;

endpackage

// File: rtl/target_mem_array.sv
// Single-port byte RAM: synchronous write, combinational read on the same address.
module target_mem_array #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/target_mem_core.sv
// Target-side memory core behind split_target_port: writes, latency-delayed reads.
// Optional split reads are compiled in with the TARGET_MEM_SPLIT_EN macro.
module target_mem_core
    import target_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = BUS_DATA_WIDTH,
    parameter int READ_LATENCY    = 2,
    parameter int SPLIT_THRESHOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BUS_ADDR_WIDTH-1:0] target_addr_in,
    input  logic                      target_addr_in_valid,
    input  logic [DATA_WIDTH-1:0]     target_data_in,
    input  logic                      target_data_in_valid,
    input  logic                      target_rw,
    output logic [DATA_WIDTH-1:0]     target_data_out,
    output logic                      target_data_out_valid,
    output logic                      target_ready,
    output logic                      target_ack,
    output logic                      err_overrun,
    output logic                      split_req,
    input  logic                      split_grant
);

    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

`ifdef TARGET_MEM_SPLIT_EN
    localparam bit USE_SPLIT = (READ_LATENCY >= SPLIT_THRESHOLD);
`else
    localparam bit USE_SPLIT = 1'b0;
`endif

    state_t                r_state;
    state_t                w_stateNext;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_cnt;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dataOut;
    logic                  r_dataValid;
    logic                  r_err;

    logic                  w_memWe;
    logic [ADDR_WIDTH-1:0] w_memAddr;
    logic [DATA_WIDTH-1:0] w_memRdata;
    logic                  w_ackSet;
    logic                  w_pulse;
    logic                  w_latchAddr;
    logic                  w_loadCnt;
    logic                  w_errSet;
    logic                  w_counting;

    // Same-cycle writes in IDLE use the live address; everything else uses the latched one.
    assign w_memAddr = (r_state == IDLE) ? target_addr_in[ADDR_WIDTH-1:0] : r_addr;

    target_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk    (clk),
        .i_we   (w_memWe),
        .i_addr (w_memAddr),
        .i_wdata(target_data_in),
        .o_rdata(w_memRdata)
    );

    always_comb begin
        w_stateNext = r_state;
        w_memWe     = 1'b0;
        w_ackSet    = 1'b0;
        w_pulse     = 1'b0;
        w_latchAddr = 1'b0;
        w_loadCnt   = 1'b0;
        w_errSet    = 1'b0;
        case (r_state)
            IDLE: begin
                if (target_addr_in_valid) begin
                    if (target_rw == RW_WRITE) begin
                        if (target_data_in_valid) begin
                            w_memWe  = 1'b1;
                            w_ackSet = 1'b1;
                        end else begin
                            w_latchAddr = 1'b1;
                            w_stateNext = WR_WAIT_DATA;
                        end
                    end else begin
                        w_latchAddr = 1'b1;
                        w_loadCnt   = 1'b1;
                        w_stateNext = USE_SPLIT ? RD_SPLIT : RD_WAIT;
                    end
                end
            end
            WR_WAIT_DATA: begin
                w_errSet = target_addr_in_valid;
                if (target_data_in_valid) begin
                    w_memWe     = 1'b1;
                    w_ackSet    = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            RD_WAIT: begin
                w_errSet = target_addr_in_valid | target_data_in_valid;
                if (r_cnt == 4'd0) begin
                    w_pulse     = 1'b1;
                    w_stateNext = IDLE;
                end
            end
`ifdef TARGET_MEM_SPLIT_EN
            RD_SPLIT: begin
                w_errSet = target_addr_in_valid | target_data_in_valid;
                if ((r_cnt == 4'd0) && split_grant) begin
                    w_pulse     = 1'b1;
                    w_stateNext = IDLE;
                end
            end
`endif
            default: w_stateNext = IDLE;
        endcase
    end

    assign w_counting = (r_state == RD_WAIT) || (r_state == RD_SPLIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_cnt       <= 4'd0;
            r_ack       <= 1'b0;
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_ack       <= w_ackSet;
            r_dataValid <= w_pulse;
            if (w_latchAddr) begin
                r_addr <= target_addr_in[ADDR_WIDTH-1:0];
            end
            // The counter parks at zero while a split read waits for its grant.
            if (w_loadCnt) begin
                r_cnt <= LAT_LOAD;
            end else if (w_counting && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_pulse) begin
                r_dataOut <= w_memRdata;
            end
            if (w_errSet) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef TARGET_MEM_SPLIT_EN
    logic r_splitReq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_splitReq <= 1'b0;
        end else begin
            r_splitReq <= (r_state == RD_SPLIT) && !w_pulse;
        end
    end

    assign split_req = r_splitReq;

    logic w_unused;
    assign w_unused = &{1'b0, target_addr_in[BUS_ADDR_WIDTH-1:ADDR_WIDTH]};
`else
    assign split_req = 1'b0;

    logic w_unused;
    assign w_unused = &{1'b0, target_addr_in[BUS_ADDR_WIDTH-1:ADDR_WIDTH],
                        split_grant, (SPLIT_THRESHOLD > 0)};
`endif

    assign target_ready          = (r_state == IDLE);
    assign target_ack            = r_ack;
    assign target_data_out       = r_dataOut;
    assign target_data_out_valid = r_dataValid;
    assign err_overrun           = r_err;

endmodule
